// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states
// and small priority helpers.
package irq_ctrl_pkg;

    localparam int N_SRC_MAX = 5;

    localparam logic [2:0] IRQ_PEND  = 3'd0;
    localparam logic [2:0] IRQ_MASK  = 3'd1;
    localparam logic [2:0] IRQ_MODE  = 3'd2;
    localparam logic [2:0] IRQ_CLAIM = 3'd3;
    localparam logic [2:0] IRQ_RAW   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2,
        ST_DRAIN   = 2'd3
    } irq_state_e;

    // Lowest set index wins; scanning downwards lets the lowest overwrite last.
    function automatic logic [2:0] lowest_set(input logic [N_SRC_MAX-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_SRC_MAX - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [N_SRC_MAX-1:0] onehot(input logic [2:0] id);
        return 5'd1 << id;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one raw request line, with a rising-edge strobe
// on the synchronised output.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain_r;
    logic                   prev_r;

    // Shift the raw line through the chain and remember last cycle's synchronised value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= '0;
            prev_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], raw};
            prev_r  <= chain_r[SYNC_STAGES-1];
        end
    end

    assign sync = chain_r[SYNC_STAGES-1];
    assign rise = sync & ~prev_r;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises peripheral requests, latches them as pending,
// masks them and presents a single lowest-index winner to the CPU INT input.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_raw,
    input  logic             exl,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic [4:0]       int_out,
    output logic [2:0]       claim_id
);

    localparam logic [N_SRC_MAX-1:0] SRC_MASK = 5'((32'd1 << N_SRC) - 32'd1);

    logic [N_SRC_MAX-1:0] sync_s;
    logic [N_SRC_MAX-1:0] rise_s;
    logic [N_SRC_MAX-1:0] pend_r;
    logic [N_SRC_MAX-1:0] mask_r;
    logic [N_SRC_MAX-1:0] mode_r;
    logic [N_SRC_MAX-1:0] pend_next_s;
    logic [N_SRC_MAX-1:0] elig_s;
    logic [2:0]           win_s;
    logic                 claim_elig_s;
    logic                 wr_pend_s;
    logic                 wr_mask_s;
    logic                 wr_mode_s;
    logic                 wd_unused_s;

    irq_state_e           state_r;
    irq_state_e           state_next_s;
    logic [N_SRC_MAX-1:0] int_r;
    logic [N_SRC_MAX-1:0] int_next_s;
    logic [2:0]           claim_r;
    logic [2:0]           claim_next_s;

    for (genvar g = 0; g < N_SRC_MAX; g++) begin : g_src
        if (g < N_SRC) begin : g_used
            irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .clk  (clk),
                .rst  (rst),
                .raw  (irq_raw[g]),
                .sync (sync_s[g]),
                .rise (rise_s[g])
            );
        end else begin : g_tied
            assign sync_s[g] = 1'b0;
            assign rise_s[g] = 1'b0;
        end
    end

    assign wr_pend_s   = we && (addr == IRQ_PEND);
    assign wr_mask_s   = we && (addr == IRQ_MASK);
    assign wr_mode_s   = we && (addr == IRQ_MODE);
    assign wd_unused_s = ^wd[31:N_SRC_MAX];

    // Per-source pending update; in edge mode a new edge beats a same-cycle W1C.
    always_comb begin
        pend_next_s = 5'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode_r[i]) begin
                if (rise_s[i]) begin
                    pend_next_s[i] = 1'b1;
                end else if (wr_pend_s && wd[i]) begin
                    pend_next_s[i] = 1'b0;
                end else begin
                    pend_next_s[i] = pend_r[i];
                end
            end else begin
                pend_next_s[i] = sync_s[i];
            end
        end
    end

    // Software-visible pending, mask and mode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= 5'd0;
            mask_r <= 5'd0;
            mode_r <= 5'd0;
        end else begin
            pend_r <= pend_next_s;
            mask_r <= wr_mask_s ? (wd[N_SRC_MAX-1:0] & SRC_MASK) : mask_r;
            mode_r <= wr_mode_s ? (wd[N_SRC_MAX-1:0] & SRC_MASK) : mode_r;
        end
    end

    assign elig_s       = pend_r & mask_r;
    assign win_s        = lowest_set(elig_s);
    assign claim_elig_s = elig_s[claim_r];

    // Next-state logic; the winner is only chosen from IDLE, so no preemption.
    always_comb begin
        state_next_s = state_r;
        int_next_s   = int_r;
        claim_next_s = claim_r;
        case (state_r)
            ST_IDLE: begin
                if (elig_s != 5'd0) begin
                    state_next_s = ST_ASSERT;
                    claim_next_s = win_s;
                    int_next_s   = onehot(win_s);
                end else begin
                    int_next_s   = 5'd0;
                end
            end
            ST_ASSERT: begin
                if (!claim_elig_s) begin
                    state_next_s = ST_IDLE;
                    int_next_s   = 5'd0;
                end else if (exl) begin
                    state_next_s = ST_SERVICE;
                end else begin
                    state_next_s = ST_ASSERT;
                end
            end
            ST_SERVICE: begin
                if (!claim_elig_s) begin
                    state_next_s = ST_DRAIN;
                    int_next_s   = 5'd0;
                end else begin
                    state_next_s = ST_SERVICE;
                end
            end
            ST_DRAIN: begin
                int_next_s = 5'd0;
                if (!exl) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                int_next_s   = 5'd0;
            end
        endcase
    end

    // FSM state, registered INT vector and latched claim id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            int_r   <= 5'd0;
            claim_r <= 3'd0;
        end else begin
            state_r <= state_next_s;
            int_r   <= int_next_s;
            claim_r <= claim_next_s;
        end
    end

    assign int_out  = int_r;
    assign claim_id = claim_r;

    // Single-cycle read port.
    always_comb begin
        case (addr)
            IRQ_PEND:  rd = {27'd0, pend_r};
            IRQ_MASK:  rd = {27'd0, mask_r};
            IRQ_MODE:  rd = {27'd0, mode_r};
            IRQ_CLAIM: rd = {(state_r != ST_IDLE), 28'd0, claim_r};
            IRQ_RAW:   rd = {27'd0, sync_s};
            default:   rd = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register table, directed corner sequences,
// then randomized traffic against a cycle-level reference model.
module tb_irq_ctrl;

    localparam int SYNC = 2;
    localparam int PH_IDLE = 0, PH_WAIT_CPU = 1, PH_IN_HANDLER = 2, PH_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  irq_raw;
    logic        exl;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [4:0]  int_out;
    logic [2:0]  claim_id;

    int n_cmp = 0;
    int n_bad = 0;

    irq_ctrl #(.N_SRC(5), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_raw  (irq_raw),
        .exl      (exl),
        .we       (we),
        .addr     (addr),
        .wd       (wd),
        .rd       (rd),
        .int_out  (int_out),
        .claim_id (claim_id)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        wd   = d;
        tick();
        we   = 1'b0;
        wd   = 32'd0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd;
    endtask

    task automatic wait_int(input string name, input logic [4:0] exp, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (int_out === exp) break;
            tick();
        end
        check(name, 32'(int_out), 32'(exp));
    endtask

    // ---------------- reference model ----------------
    bit [4:0] m_pend, m_mask, m_mode, m_int;
    int       m_phase;
    int       m_id;
    bit [4:0] hist[$];

    task automatic model_reset();
        m_pend = 5'd0; m_mask = 5'd0; m_mode = 5'd0; m_int = 5'd0;
        m_phase = PH_IDLE; m_id = 0;
        hist = {};
        for (int k = 0; k <= SYNC; k++) hist.push_back(5'd0);
    endtask

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        case (a)
            3'd0: return {27'd0, m_pend};
            3'd1: return {27'd0, m_mask};
            3'd2: return {27'd0, m_mode};
            3'd3: return {(m_phase != PH_IDLE), 28'd0, 3'(m_id)};
            3'd4: return {27'd0, hist[SYNC-1]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        bit [4:0] s, s_old, elig, np;
        int win;
        s = hist[SYNC-1];
        s_old = hist[SYNC];
        elig = m_pend & m_mask;
        win = -1;
        for (int i = 0; i < 5; i++) if (elig[i] && win < 0) win = i;
        for (int i = 0; i < 5; i++) begin
            if (!m_mode[i]) np[i] = s[i];
            else if (s[i] && !s_old[i]) np[i] = 1'b1;
            else if (we && addr == 3'd0 && wd[i]) np[i] = 1'b0;
            else np[i] = m_pend[i];
        end
        case (m_phase)
            PH_IDLE: if (win >= 0) begin m_phase = PH_WAIT_CPU; m_id = win; m_int = 5'd1 << win; end
            PH_WAIT_CPU: begin
                if (!elig[m_id]) begin m_phase = PH_IDLE; m_int = 5'd0; end
                else if (exl) m_phase = PH_IN_HANDLER;
            end
            PH_IN_HANDLER: if (!elig[m_id]) begin m_phase = PH_DRAIN; m_int = 5'd0; end
            default: if (!exl) m_phase = PH_IDLE;
        endcase
        if (we && addr == 3'd1) m_mask = wd[4:0];
        if (we && addr == 3'd2) m_mode = wd[4:0];
        m_pend = np;
        hist.push_front(irq_raw);
        void'(hist.pop_back());
    endtask

    // ---------------- register table ----------------
    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];
    logic [31:0] r;

    initial begin
        rst = 1'b1; irq_raw = 5'd0; exl = 1'b0; we = 1'b0; addr = 3'd0; wd = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_int_out", 32'(int_out), 32'd0);
        check("reset_claim_id", 32'(claim_id), 32'd0);
        read_reg(3'd0, r); check("reset_pend", r, 32'd0);
        read_reg(3'd3, r); check("reset_claim", r, 32'd0);
        tick();

        vecs[0]  = '{1'b1, 3'd1, 32'h0000_001F, 3'd1, 32'h0000_001F};
        vecs[1]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 3'd1, 32'h0000_001F};
        vecs[2]  = '{1'b1, 3'd2, 32'h0000_000A, 3'd2, 32'h0000_000A};
        vecs[3]  = '{1'b1, 3'd2, 32'hFFFF_FFF5, 3'd2, 32'h0000_0015};
        vecs[4]  = '{1'b1, 3'd5, 32'hFFFF_FFFF, 3'd5, 32'h0000_0000};
        vecs[5]  = '{1'b0, 3'd0, 32'h0000_0000, 3'd6, 32'h0000_0000};
        vecs[6]  = '{1'b1, 3'd7, 32'h1234_5678, 3'd7, 32'h0000_0000};
        vecs[7]  = '{1'b1, 3'd0, 32'h0000_001F, 3'd0, 32'h0000_0000};
        vecs[8]  = '{1'b0, 3'd0, 32'h0000_0000, 3'd3, 32'h0000_0000};
        vecs[9]  = '{1'b0, 3'd0, 32'h0000_0000, 3'd4, 32'h0000_0000};
        vecs[10] = '{1'b1, 3'd1, 32'h0000_0000, 3'd1, 32'h0000_0000};
        vecs[11] = '{1'b0, 3'd0, 32'h0000_0000, 3'd2, 32'h0000_0015};
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].we) bus_write(vecs[v].waddr, vecs[v].wdata);
            read_reg(vecs[v].raddr, r);
            check($sformatf("table_%0d", v), r, vecs[v].exp);
        end

        // Edge mode, single source on line 2
        bus_write(3'd1, 32'h1F);
        bus_write(3'd2, 32'h04);
        irq_raw = 5'b00100;
        tick();
        irq_raw = 5'd0;
        tick();
        tick();
        read_reg(3'd0, r); check("edge_pend_latency", r, 32'h04);
        check("edge_int_not_yet", 32'(int_out), 32'd0);
        tick();
        check("edge_int_out", 32'(int_out), 32'h04);
        check("edge_claim_id", 32'(claim_id), 32'd2);
        exl = 1'b1;
        tick();
        read_reg(3'd3, r); check("edge_claim_service", r, 32'h8000_0002);
        bus_write(3'd0, 32'h04);
        check("edge_int_held_w1c_edge", 32'(int_out), 32'h04);
        tick();
        check("edge_int_drain", 32'(int_out), 32'd0);
        read_reg(3'd3, r); check("edge_claim_drain", r, 32'h8000_0002);
        exl = 1'b0;
        tick();
        read_reg(3'd3, r); check("edge_idle_valid", 32'(r[31]), 32'd0);

        // Priority with no preemption, level mode
        bus_write(3'd2, 32'h0);
        irq_raw = 5'b01000;
        wait_int("prio_int3", 5'b01000, 10);
        exl = 1'b1;
        tick();
        irq_raw = 5'b01001;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("prio_no_preempt", 32'(int_out), 32'h08);
        end
        irq_raw = 5'b00001;
        wait_int("prio_drop", 5'd0, 10);
        read_reg(3'd3, r); check("prio_claim_drain", r, 32'h8000_0003);
        exl = 1'b0;
        tick();
        check("prio_idle_gap", 32'(int_out), 32'd0);
        tick();
        check("prio_int0", 32'(int_out), 32'h01);
        irq_raw = 5'd0;
        wait_int("prio_retract", 5'd0, 10);

        // Retract by masking while waiting for the CPU
        irq_raw = 5'b00010;
        wait_int("retract_int1", 5'b00010, 10);
        bus_write(3'd1, 32'h0);
        tick();
        check("retract_int_out", 32'(int_out), 32'd0);
        read_reg(3'd3, r); check("retract_claim_valid", 32'(r[31]), 32'd0);
        irq_raw = 5'd0;
        repeat (4) tick();

        // Simultaneous edge set and W1C on bit 1
        bus_write(3'd2, 32'h1F);
        irq_raw = 5'b00010;
        tick();
        tick();
        bus_write(3'd0, 32'h02);
        read_reg(3'd0, r); check("set_beats_clear", r, 32'h02);
        bus_write(3'd0, 32'h02);
        read_reg(3'd0, r); check("w1c_after_edge", r, 32'h00);
        irq_raw = 5'd0;
        repeat (3) tick();

        // Level mode W1C is ineffective while the line is high
        bus_write(3'd2, 32'h0);
        irq_raw = 5'b10000;
        repeat (4) tick();
        read_reg(3'd0, r); check("level_pend", r, 32'h10);
        bus_write(3'd0, 32'h10);
        read_reg(3'd0, r); check("level_w1c_ignored", r, 32'h10);
        read_reg(3'd5, r); check("addr5_zero", r, 32'd0);
        read_reg(3'd6, r); check("addr6_zero", r, 32'd0);
        tick();
        read_reg(3'd7, r); check("addr7_zero", r, 32'd0);
        irq_raw = 5'd0;
        repeat (4) tick();

        // Asynchronous reset in the middle of ASSERT
        bus_write(3'd1, 32'h1F);
        irq_raw = 5'b00100;
        wait_int("rst_pre_int", 5'b00100, 10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_int", 32'(int_out), 32'd0);
        check("rst_async_claim", 32'(claim_id), 32'd0);
        irq_raw = 5'd0;
        tick();
        rst = 1'b0;
        model_reset();
        read_reg(3'd0, r); check("rst_pend", r, 32'd0);
        read_reg(3'd1, r); check("rst_mask", r, 32'd0);
        read_reg(3'd2, r); check("rst_mode", r, 32'd0);
        read_reg(3'd3, r); check("rst_claim", r, 32'd0);

        // Randomized traffic against the reference model
        tick();
        model_edge();
        for (int c = 0; c < 1500; c++) begin
            irq_raw = irq_raw ^ (5'($urandom) & 5'($urandom) & 5'($urandom));
            if ($urandom_range(0, 5) == 0) exl = ~exl;
            we   = ($urandom_range(0, 3) == 0);
            addr = 3'($urandom_range(0, 7));
            wd   = $urandom;
            #1;
            if (addr == 3'd3 && m_phase == PH_IDLE)
                check("rand_claim_valid", 32'(rd[31]), 32'd0);
            else
                check("rand_rd", rd, model_rd(addr));
            @(posedge clk);
            model_edge();
            #1;
            check("rand_int_out", 32'(int_out), 32'(m_int));
            if (m_phase != PH_IDLE) check("rand_claim_id", 32'(claim_id), 32'(m_id));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
